pwm_capture: RTL and testbench

- Measures an external PWM waveform and reports its period, high time and normalised duty value.
- The duty value is on the same 0..2^BITS-1 scale as the team's pwm generator, so a captured value can drive segdisp directly.
- The block is the receive end of the pwm interface. It is used for loop-back checking of the pwm/LED path and for reading PWM from off-board sources.

---
 rtl/pwm_cap_pkg.sv | 18 +
 rtl/pwm_capture_if.sv | 39 +++
 rtl/pwm_div.sv | 112 +++++++++++
 rtl/pwm_capture.sv | 179 +++++++++++++++++
 tb/tb_pwm_capture.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_cap_pkg.sv
// Shared constants for the PWM capture block: state encodings for the
// measurement FSM and the divider, and the default resolution/counter
// widths that must stay in step with the pwm generator.
package pwm_cap_pkg;

  // Default duty resolution and counter width shared with the generator
  localparam int BITS_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  // Measurement FSM encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEAS = 1'b1;

  // Divider FSM encoding
  localparam logic [0:0] D_IDLE = 1'b0;
  localparam logic [0:0] D_RUN  = 1'b1;

endpackage

// File: rtl/pwm_capture_if.sv
// Receive side of the pwm link: the raw PWM input plus the measurement
// results. The capture block is the slave; whoever drives the waveform and
// consumes results is the master.
interface pwm_capture_if
  import pwm_cap_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             pwm_in;
  logic [BITS-1:0]  duty;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output pwm_in,
    input  duty,
    input  period,
    input  high_time,
    input  valid,
    input  stuck,
    input  stuck_level
  );

  modport slave (
    input  pwm_in,
    output duty,
    output period,
    output high_time,
    output valid,
    output stuck,
    output stuck_level
  );

endinterface

// File: rtl/pwm_div.sv
// Sequential restoring divider producing a BITS-wide quotient.
// The caller guarantees num[CNT_W+BITS-1:BITS] < den, so the upper part of
// the numerator is loaded straight into the remainder and only the low BITS
// numerator bits are iterated. The first iteration is folded into the start
// cycle, so done pulses BITS clk after start.
module pwm_div
  import pwm_cap_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W+BITS-1:0] num,
  input  logic [CNT_W-1:0]      den,
  output logic                  busy,
  output logic                  done,
  output logic [BITS-1:0]       quot
);

  localparam int            CW       = $clog2(BITS + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

  logic [0:0]       state_r;
  logic [CNT_W-1:0] rem_r;
  logic [CNT_W-1:0] den_r;
  logic [BITS-1:0]  low_r;
  logic [BITS-1:0]  q_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;
  logic [CNT_W:0]   step_s;

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  // Returns {quotient_bit, new_remainder}.
  function automatic logic [CNT_W:0] div_step(
    input logic [CNT_W-1:0] rem,
    input logic             nbit,
    input logic [CNT_W-1:0] d
  );
    logic [CNT_W:0] sh;
    logic [CNT_W:0] diff;
    sh   = {rem, nbit};
    diff = sh - {1'b0, d};
    if (sh >= {1'b0, d}) begin
      div_step = {1'b1, diff[CNT_W-1:0]};
    end else begin
      div_step = {1'b0, sh[CNT_W-1:0]};
    end
  endfunction

  // Select operands for this cycle's step: fresh inputs when idle, state when running
  always_comb begin
    if (state_r == D_IDLE) begin
      step_s = div_step(num[CNT_W+BITS-1:BITS], num[BITS-1], den);
    end else begin
      step_s = div_step(rem_r, low_r[BITS-1], den_r);
    end
  end

  // Divider state machine: load and first step on start, then BITS-1 more steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= D_IDLE;
      rem_r   <= {CNT_W{1'b0}};
      den_r   <= {CNT_W{1'b0}};
      low_r   <= {BITS{1'b0}};
      q_r     <= {BITS{1'b0}};
      cnt_r   <= {CW{1'b0}};
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        D_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            rem_r   <= step_s[CNT_W-1:0];
            q_r     <= {{(BITS-1){1'b0}}, step_s[CNT_W]};
            low_r   <= {num[BITS-2:0], 1'b0};
            den_r   <= den;
            cnt_r   <= CNT_ONE;
            state_r <= D_RUN;
          end else begin
            state_r <= D_IDLE;
          end
        end
        D_RUN: begin
          rem_r <= step_s[CNT_W-1:0];
          q_r   <= {q_r[BITS-2:0], step_s[CNT_W]};
          low_r <= {low_r[BITS-2:0], 1'b0};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= D_IDLE;
            done_r  <= 1'b1;
          end else begin
            state_r <= D_RUN;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= D_IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state_r == D_RUN);
  assign done = done_r;
  assign quot = q_r;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input
// between consecutive rising edges and reports duty on the generator's
// 0..2^BITS-1 scale. A missing rising edge for TIMEOUT cycles is reported as
// a stuck input with the level it is stuck at.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int BITS    = BITS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 2**CNT_W - 1
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Input synchroniser and edge register
  logic sync_a_r;
  logic sync_b_r;
  logic s_cur_r;
  logic s_prev_r;

  // Measurement state
  logic [0:0]       state_r;
  logic [CNT_W-1:0] pcnt_r;
  logic [CNT_W-1:0] hcnt_r;
  logic [CNT_W-1:0] per_pend_r;
  logic [CNT_W-1:0] high_pend_r;
  logic             halt_r;

  // Result registers
  logic [BITS-1:0]  duty_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] high_time_r;
  logic             valid_r;
  logic             stuck_r;
  logic             stuck_level_r;

  // Control
  logic             rise_s;
  logic             div_active_s;
  logic             accept_s;
  logic             at_limit_s;
  logic             timeout_s;
  logic             div_busy_s;
  logic             div_done_s;
  logic [BITS-1:0]  div_q_s;

  // Two-flop synchroniser followed by the current/previous level pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_r <= 1'b0;
      sync_b_r <= 1'b0;
      s_cur_r  <= 1'b0;
      s_prev_r <= 1'b0;
    end else begin
      sync_a_r <= bus.pwm_in;
      sync_b_r <= sync_a_r;
      s_cur_r  <= sync_b_r;
      s_prev_r <= s_cur_r;
    end
  end

  // Edge detect, divider admission and timeout qualification.
  // A rise is only handed to the divider when neither the divider nor its
  // result write-back is in flight; otherwise the measurement is dropped.
  // A timeout waits while the divider is active so two valids never collide.
  always_comb begin
    rise_s       = s_cur_r & ~s_prev_r;
    div_active_s = div_busy_s | div_done_s;
    if (rise_s && (state_r == MEAS) && !div_active_s && !valid_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if ((pcnt_r == TO_VAL) && !halt_r && !rise_s) begin
      at_limit_s = 1'b1;
    end else begin
      at_limit_s = 1'b0;
    end
    if (at_limit_s && !div_active_s) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Measurement FSM and period/high-time counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pcnt_r      <= {CNT_W{1'b0}};
      hcnt_r      <= {CNT_W{1'b0}};
      per_pend_r  <= {CNT_W{1'b0}};
      high_pend_r <= {CNT_W{1'b0}};
      halt_r      <= 1'b0;
    end else if (rise_s) begin
      // The rise cycle itself is the first cycle of the next period, and it is high
      pcnt_r  <= CNT_ONE;
      hcnt_r  <= CNT_ONE;
      halt_r  <= 1'b0;
      state_r <= MEAS;
      if (accept_s) begin
        per_pend_r  <= pcnt_r;
        high_pend_r <= hcnt_r;
      end else begin
        per_pend_r  <= per_pend_r;
        high_pend_r <= high_pend_r;
      end
    end else if (timeout_s) begin
      // Stop counting until the input shows a rising edge again
      state_r <= IDLE;
      halt_r  <= 1'b1;
    end else if (halt_r || at_limit_s) begin
      pcnt_r <= pcnt_r;
      hcnt_r <= hcnt_r;
    end else begin
      pcnt_r <= pcnt_r + CNT_ONE;
      if ((state_r == MEAS) && s_cur_r) begin
        hcnt_r <= hcnt_r + CNT_ONE;
      end else begin
        hcnt_r <= hcnt_r;
      end
    end
  end

  pwm_div #(
    .BITS  (BITS),
    .CNT_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (accept_s),
    .num   ({hcnt_r, {BITS{1'b0}}}),
    .den   (pcnt_r),
    .busy  (div_busy_s),
    .done  (div_done_s),
    .quot  (div_q_s)
  );

  // Result registers: written on a finished division or on a timeout, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r        <= {BITS{1'b0}};
      period_r      <= {CNT_W{1'b0}};
      high_time_r   <= {CNT_W{1'b0}};
      valid_r       <= 1'b0;
      stuck_r       <= 1'b0;
      stuck_level_r <= 1'b0;
    end else if (div_done_s) begin
      duty_r        <= div_q_s;
      period_r      <= per_pend_r;
      high_time_r   <= high_pend_r;
      valid_r       <= 1'b1;
      stuck_r       <= 1'b0;
      stuck_level_r <= 1'b0;
    end else if (timeout_s) begin
      duty_r        <= s_cur_r ? {BITS{1'b1}} : {BITS{1'b0}};
      period_r      <= {CNT_W{1'b0}};
      high_time_r   <= {CNT_W{1'b0}};
      valid_r       <= 1'b1;
      stuck_r       <= 1'b1;
      stuck_level_r <= s_cur_r;
    end else begin
      valid_r       <= 1'b0;
    end
  end

  assign bus.duty        = duty_r;
  assign bus.period      = period_r;
  assign bus.high_time   = high_time_r;
  assign bus.valid       = valid_r;
  assign bus.stuck       = stuck_r;
  assign bus.stuck_level = stuck_level_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table of waveforms with hand-derived
// results, randomised waveforms against an arithmetic model, and sequences
// for timeout/recovery and reset during a division.
module tb_pwm_capture;

  localparam int BITS    = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 65535;
  localparam int LAT     = 3 + BITS + 1;  // input edge to valid sample
  localparam int GAP     = BITS + 2;      // minimum spacing between accepted rises

  logic clk;
  logic rst;
  int   cyc;
  int   last_rise;
  int   total;
  int   bad;

  pwm_capture_if bus ();

  pwm_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    int rise_cyc;
    int duty;
    int period;
    int high;
    int stuck;
    int level;
  } obs_t;

  typedef struct {
    int h;
    int l;
    int n;
    int per;
    int high;
    int duty;
  } vec_t;

  obs_t obs_q[$];
  int   rise_q[$];
  vec_t vecs[7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid strobe with its cycle and the most recent input rise
  always @(posedge clk) begin
    obs_t o;
    #1;
    if (bus.valid === 1'b1) begin
      o.cyc      = cyc;
      o.rise_cyc = last_rise;
      o.duty     = int'(bus.duty);
      o.period   = int'(bus.period);
      o.high     = int'(bus.high_time);
      o.stuck    = int'(bus.stuck);
      o.level    = int'(bus.stuck_level);
      obs_q.push_back(o);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);
    obs_q.delete();
    rise_q.delete();
  endtask

  // n periods of h cycles high then l cycles low, starting on a negedge
  task automatic run_wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pwm_in = 1'b1;
      last_rise  = cyc;
      rise_q.push_back(cyc);
      idle(h);
      bus.pwm_in = 1'b0;
      idle(l);
    end
  endtask

  // Number of results from n evenly spaced rises: the first rise only arms,
  // later rises are measured unless they come too soon after the last accepted one
  function automatic int model_count(input int p, input int n);
    int acc;
    int cnt;
    acc = -1;
    cnt = 0;
    for (int i = 1; i < n; i++) begin
      if (acc < 0 || (i * p - acc) >= GAP) begin
        cnt++;
        acc = i * p;
      end
    end
    return cnt;
  endfunction

  task automatic check_stream(input string tag, input int h, input int l, input int n,
                              input int e_per, input int e_high, input int e_duty);
    do_reset();
    run_wave(h, l, n);
    idle(20);
    chk({tag, " count"}, obs_q.size(), model_count(h + l, n));
    for (int k = 0; k < obs_q.size(); k++) begin
      chk($sformatf("%s[%0d] duty", tag, k), obs_q[k].duty, e_duty);
      chk($sformatf("%s[%0d] period", tag, k), obs_q[k].period, e_per);
      chk($sformatf("%s[%0d] high", tag, k), obs_q[k].high, e_high);
      chk($sformatf("%s[%0d] stuck", tag, k), obs_q[k].stuck, 0);
      if (h + l > LAT) begin
        chk($sformatf("%s[%0d] latency", tag, k), obs_q[k].cyc - obs_q[k].rise_cyc, LAT);
      end
      if (k > 0) begin
        chk($sformatf("%s[%0d] spacing_ok", tag, k),
            int'((obs_q[k].cyc - obs_q[k-1].cyc) >= GAP), 1);
      end
    end
  endtask

  initial begin
    int waited;
    int h;
    int l;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    last_rise = 0;
    rst       = 1'b1;
    bus.pwm_in = 1'b0;

    vecs[0] = '{h: 64,  l: 192, n: 4, per: 256, high: 64,  duty: 64};
    vecs[1] = '{h: 30,  l: 70,  n: 4, per: 100, high: 30,  duty: 76};
    vecs[2] = '{h: 255, l: 1,   n: 3, per: 256, high: 255, duty: 255};
    vecs[3] = '{h: 2,   l: 3,   n: 8, per: 5,   high: 2,   duty: 102};
    vecs[4] = '{h: 1,   l: 9,   n: 4, per: 10,  high: 1,   duty: 25};
    vecs[5] = '{h: 9,   l: 1,   n: 4, per: 10,  high: 9,   duty: 230};
    vecs[6] = '{h: 3,   l: 5,   n: 6, per: 8,   high: 3,   duty: 96};

    // Reset state
    idle(3);
    chk("rst duty", int'(bus.duty), 0);
    chk("rst period", int'(bus.period), 0);
    chk("rst high", int'(bus.high_time), 0);
    chk("rst valid", int'(bus.valid), 0);
    chk("rst stuck", int'(bus.stuck), 0);
    chk("rst level", int'(bus.stuck_level), 0);

    // Table of fixed waveforms
    for (int v = 0; v < 7; v++) begin
      check_stream($sformatf("vec%0d", v), vecs[v].h, vecs[v].l, vecs[v].n,
                   vecs[v].per, vecs[v].high, vecs[v].duty);
    end

    // Randomised waveforms against the arithmetic model
    for (int r = 0; r < 5; r++) begin
      h = int'($urandom_range(120, 1));
      l = int'($urandom_range(120, 1));
      check_stream($sformatf("rnd%0d", r), h, l, 3, h + l, h, (h << BITS) / (h + l));
    end

    // Held-low input: timeout, then recovery on the second rise
    do_reset();
    run_wave(64, 192, 3);
    idle(20);
    chk("pre_to count", obs_q.size(), 2);
    obs_q.delete();
    waited = 0;
    while (obs_q.size() == 0 && waited < TIMEOUT + 200) begin
      @(negedge clk);
      waited++;
    end
    chk("to seen", int'(obs_q.size() > 0), 1);
    if (obs_q.size() > 0) begin
      chk("to stuck", obs_q[0].stuck, 1);
      chk("to level", obs_q[0].level, 0);
      chk("to duty", obs_q[0].duty, 0);
      chk("to period", obs_q[0].period, 0);
      chk("to high", obs_q[0].high, 0);
      chk("to latency", obs_q[0].cyc - obs_q[0].rise_cyc, 3 + TIMEOUT + 1);
    end
    idle(100);
    chk("to single", obs_q.size(), 1);
    chk("to stuck hold", int'(bus.stuck), 1);
    run_wave(64, 192, 1);
    chk("rearm no result", obs_q.size(), 1);
    chk("rearm stuck", int'(bus.stuck), 1);
    run_wave(64, 192, 2);
    idle(20);
    chk("recover count", obs_q.size(), 3);
    if (obs_q.size() > 1) begin
      chk("recover duty", obs_q[1].duty, 64);
      chk("recover period", obs_q[1].period, 256);
      chk("recover high", obs_q[1].high, 64);
      chk("recover stuck", obs_q[1].stuck, 0);
      chk("recover latency", obs_q[1].cyc - obs_q[1].rise_cyc, LAT);
    end
    chk("recover stuck out", int'(bus.stuck), 0);

    // Reset during a division
    do_reset();
    run_wave(64, 192, 3);
    idle(20);
    chk("pre_rst duty", int'(bus.duty), 64);
    obs_q.delete();
    bus.pwm_in = 1'b1;
    last_rise = cyc;
    idle(8);
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    #1;
    chk("async duty", int'(bus.duty), 0);
    chk("async period", int'(bus.period), 0);
    chk("async high", int'(bus.high_time), 0);
    chk("async valid", int'(bus.valid), 0);
    chk("async stuck", int'(bus.stuck), 0);
    idle(2);
    rst = 1'b0;
    idle(5);
    chk("abort no valid", obs_q.size(), 0);
    rise_q.delete();
    run_wave(64, 192, 3);
    idle(20);
    chk("post_rst count", obs_q.size(), 2);
    if (obs_q.size() > 0 && rise_q.size() > 1) begin
      chk("post_rst duty", obs_q[0].duty, 64);
      chk("post_rst first at rise2", obs_q[0].cyc - rise_q[1], LAT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
